instr_serializer: RTL and testbench
===================================

Name: instr_serializer

Overview:
- Transmit end of the byte-wide instruction link. It is the counterpart to the receiving shift register that reassembles 16-bit instruction words and 16-bit immediates from an 8-bit bus.
- Accepts one instruction (plus immediate) per handshake. Emits it as little-endian bytes on serial_out, strobing data_ready for each byte.
- Sits between the program loader / instruction source and the CPU instruction input bus.

Parameters:
- GAP_CYCLES, 0, minimum idle cycles (data_ready low) inserted after the last byte of one instruction before the next instruction's first byte. Legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-low.
- instr_valid  input  1  source offers an instruction this cycle.
- instruction  input  16  instruction word; bits [2:0] are the opcode_t field from types.vh.
- imm  input  16  immediate; sent only for I_TYPE and M_TYPE.
- tx_hold  input  1  sink stall; freezes emission and acceptance.
- instr_ready  output  1  block accepts the instruction this cycle.
- serial_out  output  8  byte bus to the receiver.
- data_ready  output  1  serial_out holds a valid byte this cycle.
- busy  output  1  high from the accept edge until the last byte has been presented and any gap has expired.
- error  output  1  one-cycle pulse: rejected opcode.

Behaviour:
- Reset (rst==0 at posedge): serial_out=0, data_ready=0, busy=0, error=0, FSM→IDLE, gap counter=0. Any in-flight instruction is abandoned. No further bytes of it are ever sent. instr_ready is forced 0 while rst==0.
- Length: opcode I_TYPE or M_TYPE → 4 bytes. R_TYPE, B_TYPE, J_TYPE, SYS_END → 2 bytes. Any other opcode value → rejected.
- Byte order: instruction[7:0], instruction[15:8], imm[7:0], imm[15:8].
- Handshake: transfer occurs when instr_valid & instr_ready at a posedge. instr_valid may be held without transfer; inputs are sampled only at the transfer edge.
- instr_ready is combinational. It equals ~tx_hold & rst & (state==IDLE, or state==SEND with the next byte being the last and GAP_CYCLES==0).
- FSM states: IDLE, SEND, GAP.
- IDLE, transfer with a legal opcode:
  - Capture instruction and imm.
  - Register byte 0 onto serial_out and set data_ready=1 at that same edge (latency: byte 0 visible in the cycle after the accept edge).
  - Set byte index=1 and go to SEND.
- IDLE, transfer with an illegal opcode:
  - error=1 for exactly one cycle (registered).
  - No bytes emitted; stay IDLE.
- SEND, tx_hold==1 at posedge: data_ready←0, serial_out holds its last value, index unchanged.
- SEND, tx_hold==0 at posedge:
  - Present byte[index] with data_ready←1 and increment index.
  - After presenting the last byte: if GAP_CYCLES>0, go to GAP with counter=GAP_CYCLES. Otherwise go to IDLE, or, on a simultaneous transfer, the next instruction's byte 0 is presented at the following edge (back-to-back, no bubble).
- GAP: data_ready←0 each cycle. The counter decrements each edge (tx_hold is ignored). At 0 → IDLE.
- In IDLE and GAP, data_ready=0 and serial_out retains its last value.
- busy = (state != IDLE), registered.
- Simultaneous transfer with an illegal opcode at the back-to-back point: the last byte of the current instruction is still presented, error pulses, and the FSM goes to IDLE.

Optional Feature:
- Macro SERIALIZER_TXCOUNT_EN.
- When defined: extra output tx_count [15:0]. It resets to 0 and increments by 1 at the edge that presents the final byte of each legal instruction, wrapping 16'hFFFF→0. Rejected opcodes are not counted.
- When undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then offer instruction={13'h0001,R_TYPE}, imm=16'hBEEF → bytes instruction[7:0], instruction[15:8] on 2 consecutive cycles with data_ready=1, BEEF never sent; busy falls afterwards.
- Offer {ADD,3'd1,3'd0,3'd0,I_TYPE}, imm=16'h0001 → 4 consecutive data_ready bytes: instr[7:0], instr[15:8], 8'h01, 8'h00. Feeding these bytes to the instruction receiver gives valid=1 with matching instruction and imm.
- Two R_TYPE instructions with instr_valid held high, GAP_CYCLES=0 → 4 bytes with no data_ready bubble. With GAP_CYCLES=3 → exactly 3 idle cycles between them.
- M_TYPE transfer, tx_hold=1 for 2 cycles after byte 1 → data_ready=0 for 2 cycles, serial_out unchanged, then bytes 2 and 3 in order; instr_ready=0 throughout the hold.
- Opcode field outside the legal set → error=1 for one cycle, data_ready stays 0, instr_ready returns 1 the next cycle.
- Assert rst=0 after byte 1 of an I_TYPE instruction → next cycle data_ready=0, busy=0. A new R_TYPE instruction then sends only its 2 bytes. With SERIALIZER_TXCOUNT_EN, tx_count=0 after reset and 1 after the new instruction.

Source files
------------

// File: rtl/instr_serializer.sv
// instr_serializer: transmit end of the byte-wide instruction link.
// Sends each accepted instruction little-endian as 2 bytes (R/B/J/SYS_END)
// or 4 bytes (I/M, immediate appended), one byte per data_ready strobe.
// Optional feature: define SERIALIZER_TXCOUNT_EN to add the tx_count output
// (count of fully presented legal instructions).
module instr_serializer #(
  parameter int GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instruction,
  input  logic [15:0] imm,
  input  logic        tx_hold,
  output logic        instr_ready,
  output logic [7:0]  serial_out,
  output logic        data_ready,
  output logic        busy,
  output logic        error
`ifdef SERIALIZER_TXCOUNT_EN
  ,
  output logic [15:0] tx_count
`endif
);

  // opcode_t encoding shared with the receiver
  localparam logic [2:0] R_TYPE  = 3'd0;
  localparam logic [2:0] I_TYPE  = 3'd1;
  localparam logic [2:0] M_TYPE  = 3'd2;
  localparam logic [2:0] B_TYPE  = 3'd3;
  localparam logic [2:0] J_TYPE  = 3'd4;
  localparam logic [2:0] SYS_END = 3'd5;

  localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t      state;
  logic [1:0]  idx;
  logic        len4;
  logic [3:0]  gap_cnt;
  logic [15:0] instr_q;
  logic [15:0] imm_q;
  logic        is_last;
  logic        xfer;
  logic        load;
  logic [7:0]  next_byte;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == R_TYPE) || (op == I_TYPE) || (op == M_TYPE) ||
           (op == B_TYPE) || (op == J_TYPE) || (op == SYS_END);
  endfunction

  function automatic logic op_long(input logic [2:0] op);
    return (op == I_TYPE) || (op == M_TYPE);
  endfunction

  // Handshake: accept in IDLE, or on the last byte of SEND when no gap is owed
  always_comb begin
    is_last     = (idx == (len4 ? 2'd3 : 2'd1));
    instr_ready = ~tx_hold & rst &
                  ((state == IDLE) ||
                   ((state == SEND) && is_last && (GAP_CYCLES == 0)));
    xfer        = instr_valid & instr_ready;
    load        = xfer & op_legal(instruction[2:0]);
    case (idx)
      2'd0:    next_byte = instr_q[7:0];
      2'd1:    next_byte = instr_q[15:8];
      2'd2:    next_byte = imm_q[7:0];
      default: next_byte = imm_q[15:8];
    endcase
  end

  // Capture the instruction and immediate at each legal transfer edge
  always_ff @(posedge clk) begin
    if (load) begin
      instr_q <= instruction;
      imm_q   <= imm;
    end
  end

  // Control FSM with registered byte bus, strobe, busy and error outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= 2'd0;
      len4       <= 1'b0;
      gap_cnt    <= 4'd0;
      serial_out <= 8'h00;
      data_ready <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
`ifdef SERIALIZER_TXCOUNT_EN
      tx_count   <= 16'h0000;
`endif
    end else begin
      error <= 1'b0;
      case (state)
        IDLE: begin
          data_ready <= 1'b0;
          if (xfer) begin
            if (load) begin
              serial_out <= instruction[7:0];
              data_ready <= 1'b1;
              idx        <= 2'd1;
              len4       <= op_long(instruction[2:0]);
              state      <= SEND;
              busy       <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
        end
        SEND: begin
          if (tx_hold) begin
            data_ready <= 1'b0;
          end else begin
            serial_out <= next_byte;
            data_ready <= 1'b1;
            idx        <= idx + 2'd1;
            if (is_last) begin
`ifdef SERIALIZER_TXCOUNT_EN
              tx_count <= tx_count + 16'd1;
`endif
              if (GAP_CYCLES > 0) begin
                state   <= GAP;
                gap_cnt <= GAP_INIT;
              end else if (load) begin
                // Back-to-back: new byte 0 goes out on the following edge
                idx   <= 2'd0;
                len4  <= op_long(instruction[2:0]);
                state <= SEND;
              end else begin
                if (xfer) error <= 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
        GAP: begin
          data_ready <= 1'b0;
          if (gap_cnt <= 4'd1) begin
            gap_cnt <= 4'd0;
            state   <= IDLE;
            busy    <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_serializer.sv
// Directed testbench for instr_serializer: one instance with no gap and one
// with a 3-cycle gap, sharing all inputs except instr_valid.
module tb_instr_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_valid2 = 1'b0;
  logic [15:0] instruction = 16'h0000;
  logic [15:0] imm = 16'h0000;
  logic        tx_hold = 1'b0;

  logic        instr_ready, data_ready, busy, error;
  logic [7:0]  serial_out;
  logic        instr_ready2, data_ready2, busy2, error2;
  logic [7:0]  serial_out2;
`ifdef SERIALIZER_TXCOUNT_EN
  logic [15:0] tx_count, tx_count2;
`endif

  int ncomp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  instr_serializer #(.GAP_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
    .imm(imm), .tx_hold(tx_hold), .instr_ready(instr_ready),
    .serial_out(serial_out), .data_ready(data_ready), .busy(busy), .error(error)
`ifdef SERIALIZER_TXCOUNT_EN
    , .tx_count(tx_count)
`endif
  );

  instr_serializer #(.GAP_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid2), .instruction(instruction),
    .imm(imm), .tx_hold(tx_hold), .instr_ready(instr_ready2),
    .serial_out(serial_out2), .data_ready(data_ready2), .busy(busy2), .error(error2)
`ifdef SERIALIZER_TXCOUNT_EN
    , .tx_count(tx_count2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the byte strobe and bus value of the gap-free instance
  task automatic chk_byte(input string tag, input logic dr, input logic [7:0] b);
    chk({tag, "_dr"}, 32'(data_ready), 32'(dr));
    chk({tag, "_so"}, 32'(serial_out), 32'(b));
  endtask

  initial begin
    // Reset state
    #1;
    step(); step();
    chk("rst_dr", 32'(data_ready), 32'd0);
    chk("rst_so", 32'(serial_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    chk("rst_rdy_forced", 32'(instr_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("rdy_after_rst", 32'(instr_ready), 32'd1);

    // R_TYPE: two bytes, immediate never sent
    instruction = 16'h0008; imm = 16'hBEEF; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    chk_byte("r_b0", 1'b1, 8'h08);
    chk("r_busy0", 32'(busy), 32'd1);
    step();
    chk_byte("r_b1", 1'b1, 8'h00);
    chk("r_busy1", 32'(busy), 32'd0);
    step();
    chk_byte("r_end", 1'b0, 8'h00);
    step();
    chk_byte("r_noimm", 1'b0, 8'h00);

    // I_TYPE: four bytes including the immediate
    instruction = 16'h0201; imm = 16'h0001; instr_valid = 1'b1;
    #1;
    chk("i_rdy", 32'(instr_ready), 32'd1);
    step(); instr_valid = 1'b0;
    chk_byte("i_b0", 1'b1, 8'h01);
    step(); chk_byte("i_b1", 1'b1, 8'h02);
    step(); chk_byte("i_b2", 1'b1, 8'h01);
    step(); chk_byte("i_b3", 1'b1, 8'h00);
    chk("i_busy", 32'(busy), 32'd0);
    step(); chk("i_end_dr", 32'(data_ready), 32'd0);

    // Back-to-back R_TYPE pair with valid held, no gap
    instruction = 16'h0010; instr_valid = 1'b1;
    step();
    instruction = 16'h0018;
    chk_byte("bb_a0", 1'b1, 8'h10);
    chk("bb_rdy_last", 32'(instr_ready), 32'd1);
    step();
    instr_valid = 1'b0;
    chk_byte("bb_a1", 1'b1, 8'h00);
    chk("bb_rdy_mid", 32'(instr_ready), 32'd0);
    step(); chk_byte("bb_b0", 1'b1, 8'h18);
    chk("bb_busy", 32'(busy), 32'd1);
    step(); chk_byte("bb_b1", 1'b1, 8'h00);
    step(); chk("bb_end_dr", 32'(data_ready), 32'd0);

    // Gap instance: exactly three idle cycles between instructions
    instruction = 16'h0008; instr_valid2 = 1'b1;
    step();
    instruction = 16'h0010;
    chk("g_a0_dr", 32'(data_ready2), 32'd1);
    chk("g_a0_so", 32'(serial_out2), 32'h08);
    chk("g_rdy_nogap", 32'(instr_ready2), 32'd0);
    step();
    chk("g_a1_so", 32'(serial_out2), 32'h00);
    step(); chk("g_idle1", 32'(data_ready2), 32'd0);
    chk("g_busy", 32'(busy2), 32'd1);
    step(); chk("g_idle2", 32'(data_ready2), 32'd0);
    step(); chk("g_idle3", 32'(data_ready2), 32'd0);
    chk("g_rdy_back", 32'(instr_ready2), 32'd1);
    step(); instr_valid2 = 1'b0;
    chk("g_b0_dr", 32'(data_ready2), 32'd1);
    chk("g_b0_so", 32'(serial_out2), 32'h10);
    repeat (6) step();
    chk("g_done_busy", 32'(busy2), 32'd0);

    // M_TYPE with a two-cycle stall after byte 1
    instruction = 16'h1232; imm = 16'h5678; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    chk_byte("m_b0", 1'b1, 8'h32);
    step(); chk_byte("m_b1", 1'b1, 8'h12);
    tx_hold = 1'b1;
    #1;
    chk("m_rdy_hold0", 32'(instr_ready), 32'd0);
    step(); chk_byte("m_hold1", 1'b0, 8'h12);
    chk("m_rdy_hold1", 32'(instr_ready), 32'd0);
    step(); chk_byte("m_hold2", 1'b0, 8'h12);
    tx_hold = 1'b0;
    step(); chk_byte("m_b2", 1'b1, 8'h78);
    step(); chk_byte("m_b3", 1'b1, 8'h56);
    step(); chk("m_end_dr", 32'(data_ready), 32'd0);

    // Illegal opcode: one-cycle error, nothing sent
    instruction = 16'h0007; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    chk("bad_err", 32'(error), 32'd1);
    chk("bad_dr", 32'(data_ready), 32'd0);
    chk("bad_busy", 32'(busy), 32'd0);
    chk("bad_rdy", 32'(instr_ready), 32'd1);
    step();
    chk("bad_err_clr", 32'(error), 32'd0);
    chk("bad_dr2", 32'(data_ready), 32'd0);
`ifdef SERIALIZER_TXCOUNT_EN
    chk("cnt_before_rst", 32'(tx_count), 32'd5);
`endif

    // Reset mid I_TYPE, then a fresh R_TYPE sends only its two bytes
    instruction = 16'h0201; imm = 16'hAAAA; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    chk_byte("x_b0", 1'b1, 8'h01);
    step(); chk_byte("x_b1", 1'b1, 8'h02);
    rst = 1'b0;
    step();
    chk_byte("x_rst", 1'b0, 8'h00);
    chk("x_rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    step();
    chk("x_idle_dr", 32'(data_ready), 32'd0);
`ifdef SERIALIZER_TXCOUNT_EN
    chk("cnt_after_rst", 32'(tx_count), 32'd0);
`endif
    instruction = 16'h0028; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    chk_byte("n_b0", 1'b1, 8'h28);
    step(); chk_byte("n_b1", 1'b1, 8'h00);
    step(); chk_byte("n_end", 1'b0, 8'h00);
    step(); chk_byte("n_end2", 1'b0, 8'h00);
    chk("n_busy", 32'(busy), 32'd0);
`ifdef SERIALIZER_TXCOUNT_EN
    chk("cnt_new", 32'(tx_count), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
